// File: rtl/red_pitaya_fads_pkg.sv
// Shared definitions for the FADS sort sequencer: state encoding and default widths.
package red_pitaya_fads_pkg;

    localparam int CW_DEF = 32;
    localparam int DW_DEF = 24;
    localparam int WW_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEASURE = 3'd1,
        ST_DELAY   = 3'd2,
        ST_FIRE    = 3'd3,
        ST_DEAD    = 3'd4
    } fads_state_t;

endpackage

// File: rtl/red_pitaya_fads_sat_cnt.sv
// Saturating up-counter; clear beats a same-cycle increment.
module red_pitaya_fads_sat_cnt #(
    parameter int W = 32
) (
    input  logic         adc_clk_i,
    input  logic         adc_rst_i,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i || clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/red_pitaya_fads_sort_seq.sv
// FADS sort sequencer: qualifies droplet width, waits travel time, fires one ASG
// trigger pulse, then locks out for a dead time. Keeps droplet statistics.
module red_pitaya_fads_sort_seq
    import red_pitaya_fads_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int DW = DW_DEF,
    parameter int WW = WW_DEF
) (
    input  logic          adc_clk_i,
    input  logic          adc_rst_i,
    input  logic          sort_trig_i,
    input  logic          enable_i,
    input  logic          clear_cnt_i,
    input  logic [WW-1:0] min_width_i,
    input  logic [WW-1:0] max_width_i,
    input  logic [DW-1:0] delay_i,
    input  logic [WW-1:0] pulse_len_i,
    input  logic [WW-1:0] dead_time_i,
    output logic          asg_trig_o,
    output logic          busy_o,
    output logic [CW-1:0] droplet_cnt_o,
    output logic [CW-1:0] sort_cnt_o,
    output logic [CW-1:0] reject_cnt_o
);

    fads_state_t   state;
    logic          trig_d;
    logic [WW-1:0] width;
    logic [DW-1:0] dcnt;
    logic [WW-1:0] pcnt;
    logic [WW-1:0] tcnt;

    logic rise, fall, width_ok, in_lockout;
    logic droplet_inc, sort_inc, reject_inc;

    assign rise       = sort_trig_i & ~trig_d;
    assign fall       = ~sort_trig_i & trig_d;
    assign width_ok   = (width >= min_width_i) && (width <= max_width_i);
    assign in_lockout = (state == ST_DELAY) || (state == ST_FIRE) || (state == ST_DEAD);

    // Statistics only move while enabled; an abort cycle counts nothing.
    assign droplet_inc = enable_i && (state == ST_MEASURE) && fall;
    assign sort_inc    = enable_i && (state == ST_DELAY) && (dcnt == '0);
    assign reject_inc  = enable_i && (((state == ST_MEASURE) && fall && !width_ok) ||
                                      (in_lockout && rise));

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state      <= ST_IDLE;
            trig_d     <= 1'b0;
            width      <= '0;
            dcnt       <= '0;
            pcnt       <= '0;
            tcnt       <= '0;
            asg_trig_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            trig_d <= sort_trig_i;
            if (!enable_i) begin
                state      <= ST_IDLE;
                asg_trig_o <= 1'b0;
                busy_o     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state  <= ST_MEASURE;
                            width  <= WW'(1);
                            busy_o <= 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        if (fall) begin
                            if (width_ok) begin
                                state <= ST_DELAY;
                                dcnt  <= delay_i;
                            end else begin
                                state  <= ST_IDLE;
                                busy_o <= 1'b0;
                            end
                        end else if (width != {WW{1'b1}}) begin
                            width <= width + 1'b1;
                        end
                    end
                    ST_DELAY: begin
                        if (dcnt == '0) begin
                            state <= ST_FIRE;
                            pcnt  <= (pulse_len_i == '0) ? WW'(1) : pulse_len_i;
                        end else begin
                            dcnt <= dcnt - 1'b1;
                        end
                    end
                    // Output flop lags FIRE entry by one edge, giving the k+delay+2 alignment.
                    ST_FIRE: begin
                        if (pcnt != '0) begin
                            asg_trig_o <= 1'b1;
                            pcnt       <= pcnt - 1'b1;
                        end else begin
                            asg_trig_o <= 1'b0;
                            if (dead_time_i == '0) begin
                                state  <= ST_IDLE;
                                busy_o <= 1'b0;
                            end else begin
                                state <= ST_DEAD;
                                tcnt  <= dead_time_i - 1'b1;
                            end
                        end
                    end
                    ST_DEAD: begin
                        if (tcnt == '0) begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            tcnt <= tcnt - 1'b1;
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        asg_trig_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end
                endcase
            end
        end
    end

    red_pitaya_fads_sat_cnt #(.W(CW)) u_droplet_cnt (
        .adc_clk_i (adc_clk_i),
        .adc_rst_i (adc_rst_i),
        .clr       (clear_cnt_i),
        .inc       (droplet_inc),
        .cnt       (droplet_cnt_o)
    );

    red_pitaya_fads_sat_cnt #(.W(CW)) u_sort_cnt (
        .adc_clk_i (adc_clk_i),
        .adc_rst_i (adc_rst_i),
        .clr       (clear_cnt_i),
        .inc       (sort_inc),
        .cnt       (sort_cnt_o)
    );

    red_pitaya_fads_sat_cnt #(.W(CW)) u_reject_cnt (
        .adc_clk_i (adc_clk_i),
        .adc_rst_i (adc_rst_i),
        .clr       (clear_cnt_i),
        .inc       (reject_inc),
        .cnt       (reject_cnt_o)
    );

endmodule

// File: tb/tb_red_pitaya_fads_sort_seq.sv
// Directed bench: expected trigger pulses go to a scoreboard queue checked by a monitor.
module tb_red_pitaya_fads_sort_seq;

    localparam int CW = 4;
    localparam int DW = 24;
    localparam int WW = 16;

    logic          adc_clk = 1'b0;
    logic          adc_rst = 1'b1;
    logic          sort_trig = 1'b0;
    logic          enable = 1'b1;
    logic          clear_cnt = 1'b0;
    logic [WW-1:0] min_width = 16'd5;
    logic [WW-1:0] max_width = 16'd20;
    logic [DW-1:0] delay = 24'd100;
    logic [WW-1:0] pulse_len = 16'd50;
    logic [WW-1:0] dead_time = 16'd200;
    logic          asg_trig, busy;
    logic [CW-1:0] droplet_cnt, sort_cnt, reject_cnt;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct { int start; int len; } pulse_t;
    pulse_t exp_q[$];

    red_pitaya_fads_sort_seq #(.CW(CW), .DW(DW), .WW(WW)) dut (
        .adc_clk_i     (adc_clk),
        .adc_rst_i     (adc_rst),
        .sort_trig_i   (sort_trig),
        .enable_i      (enable),
        .clear_cnt_i   (clear_cnt),
        .min_width_i   (min_width),
        .max_width_i   (max_width),
        .delay_i       (delay),
        .pulse_len_i   (pulse_len),
        .dead_time_i   (dead_time),
        .asg_trig_o    (asg_trig),
        .busy_o        (busy),
        .droplet_cnt_o (droplet_cnt),
        .sort_cnt_o    (sort_cnt),
        .reject_cnt_o  (reject_cnt)
    );

    initial forever #4 adc_clk = ~adc_clk;
    always @(posedge adc_clk) cyc <= cyc + 1;

    // Monitor: measure each asg_trig pulse (rise edge, length) and match it to the queue.
    logic asg_prev = 1'b0;
    int   p_start  = 0;
    always @(negedge adc_clk) begin
        pulse_t e;
        int     len;
        if (asg_trig && !asg_prev) p_start = cyc;
        if (!asg_trig && asg_prev) begin
            len = cyc - p_start;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: got start=%0d len=%0d, required no pulse", p_start, len);
            end else begin
                e = exp_q.pop_front();
                if (e.start != p_start || e.len != len) begin
                    failures++;
                    $display("FAIL pulse: got start=%0d len=%0d, required start=%0d len=%0d",
                             p_start, len, e.start, e.len);
                end
            end
        end
        asg_prev = asg_trig;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge adc_clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Drive a droplet w cycles wide; k is the edge that first samples it low.
    task automatic droplet(input int w, output int k);
        sort_trig = 1'b1;
        tick(w);
        sort_trig = 1'b0;
        k = cyc + 1;
    endtask

    task automatic clear_stats();
        clear_cnt = 1'b1;
        tick(1);
        clear_cnt = 1'b0;
        tick(1);
    endtask

    task automatic expect_pulse(input int start, input int len);
        pulse_t p;
        p.start = start;
        p.len   = len;
        exp_q.push_back(p);
    endtask

    initial begin
        int k, k2;
        tick(3);
        chk("rst_asg", asg_trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_droplet", droplet_cnt, 0);
        chk("rst_sort", sort_cnt, 0);
        chk("rst_reject", reject_cnt, 0);
        adc_rst = 1'b0;
        tick(2);

        // 1: nominal sorted droplet
        droplet(10, k);
        expect_pulse(k + 102, 50);
        tick(2);
        chk("t1_busy", busy, 1);
        tick(360);
        chk("t1_droplet", droplet_cnt, 1);
        chk("t1_sort", sort_cnt, 1);
        chk("t1_reject", reject_cnt, 0);
        chk("t1_idle", busy, 0);

        // 2: too narrow and too wide
        clear_stats();
        droplet(3, k);
        tick(5);
        droplet(30, k);
        tick(5);
        chk("t2_droplet", droplet_cnt, 2);
        chk("t2_reject", reject_cnt, 2);
        chk("t2_sort", sort_cnt, 0);

        // 3: second droplet arrives during DELAY
        clear_stats();
        droplet(10, k);
        expect_pulse(k + 102, 50);
        tick(40);
        droplet(10, k2);
        tick(310);
        chk("t3_droplet", droplet_cnt, 1);
        chk("t3_reject", reject_cnt, 1);
        chk("t3_sort", sort_cnt, 1);
        droplet(10, k);
        expect_pulse(k + 102, 50);
        tick(360);
        chk("t3_droplet2", droplet_cnt, 2);
        chk("t3_sort2", sort_cnt, 2);
        chk("t3_reject2", reject_cnt, 1);

        // 4: zero delay, zero pulse length
        delay = '0;
        pulse_len = '0;
        dead_time = 16'd5;
        droplet(10, k);
        expect_pulse(k + 2, 1);
        tick(20);
        chk("t4_sort", sort_cnt, 3);

        // 5: enable dropped on cycle 10 of the pulse
        delay = 24'd100;
        pulse_len = 16'd50;
        dead_time = 16'd200;
        clear_stats();
        droplet(10, k);
        expect_pulse(k + 102, 10);
        tick(112);
        enable = 1'b0;
        tick(1);
        chk("t5_asg", asg_trig, 0);
        chk("t5_busy", busy, 0);
        chk("t5_sort", sort_cnt, 1);
        sort_trig = 1'b1;
        tick(2);
        enable = 1'b1;
        tick(5);
        chk("t5_no_start", busy, 0);
        sort_trig = 1'b0;
        tick(3);
        chk("t5_busy2", busy, 0);
        chk("t5_droplet", droplet_cnt, 1);
        chk("t5_reject", reject_cnt, 0);

        // 6: saturation, clear priority, reset mid-DELAY
        clear_stats();
        for (int i = 0; i < 17; i++) begin
            droplet(2, k);
            tick(3);
        end
        chk("t6_droplet_sat", droplet_cnt, 15);
        chk("t6_reject_sat", reject_cnt, 15);
        sort_trig = 1'b1;
        tick(2);
        sort_trig = 1'b0;
        clear_cnt = 1'b1;
        tick(1);
        clear_cnt = 1'b0;
        tick(2);
        chk("t6_clr_droplet", droplet_cnt, 0);
        chk("t6_clr_reject", reject_cnt, 0);
        min_width = 16'd1;
        droplet(5, k);
        tick(10);
        chk("t6_busy_delay", busy, 1);
        chk("t6_droplet_pre", droplet_cnt, 1);
        adc_rst = 1'b1;
        tick(1);
        chk("t6_rst_asg", asg_trig, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_droplet", droplet_cnt, 0);
        chk("t6_rst_sort", sort_cnt, 0);
        chk("t6_rst_reject", reject_cnt, 0);
        adc_rst = 1'b0;
        tick(200);

        chk("pending_pulses", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
